// File: rtl/mcycle_core.sv
// mcycle_core: parametrised multi-cycle CPU core with req/ack instruction and data memory ports
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_data fetch bus;
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_ack/dmem_rdata data bus;
//   pc, state (FSM code), dbg_out (last write-back), halted, illegal (one-cycle pulse), bus_err (sticky).
// Define MCYCLE_CORE_TIMEOUT_EN to add a 255-cycle bus timeout that sets bus_err and halts.
module mcycle_core #(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 16,
    parameter int PC_W    = 10,
    parameter int DADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_data,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         state,
    output logic [DATA_W-1:0]  dbg_out,
    output logic               halted,
    output logic               illegal,
    output logic               bus_err
);
    localparam int RW = $clog2(NREGS);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t st, nxt;
    logic [31:0] ir;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] a, b, res, alu;
    logic [3:0] op, fn;
    logic [RW-1:0] rd, rs;
    logic z, i_ok, d_ok, ill, alu_op, wr, tout;

    assign op        = ir[31:28];
    assign fn        = ir[27:24];
    assign rd        = ir[20 +: RW];
    assign rs        = ir[16 +: RW];
    assign alu_op    = op == 4'h1 || op == 4'h3;
    assign wr        = op inside {4'h1, 4'h2, 4'h3, 4'h8, 4'h9};
    assign ill       = !(op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF});
    // acks only count while the matching request is actually up
    assign i_ok      = imem_req && imem_ack;
    assign d_ok      = dmem_req && dmem_ack;
    assign imem_addr = pc;
    assign state     = st;

    always_comb begin
        case (fn)
            4'h0:    alu = a + b;
            4'h1:    alu = a - b;
            4'h2:    alu = a & b;
            4'h3:    alu = a | b;
            4'h4:    alu = a ^ b;
            4'h5:    alu = a << 1;
            4'h6:    alu = a >> 1;
            4'h7:    alu = b;
            default: alu = '0;
        endcase
    end

    always_comb begin
        nxt = st;
        case (st)
            FETCH:   nxt = i_ok ? DECODE : FETCH;
            DECODE:  nxt = EXEC;
            EXEC:    nxt = (op == 4'hC || op == 4'hD) ? FETCH :
                           op == 4'hE ? HALT :
                           (op == 4'h2 || op == 4'h4) ? MEM : WB;
            MEM:     nxt = d_ok ? WB : MEM;
            WB:      nxt = FETCH;
            default: nxt = HALT;
        endcase
        if (tout) nxt = HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= FETCH;
            pc         <= '0;
            regs       <= '{default: '0};
            z          <= 1'b0;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            res        <= '0;
            dbg_out    <= '0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            st       <= nxt;
            // requests are registered from the next state so they are up for the whole wait
            imem_req <= nxt == FETCH;
            dmem_req <= nxt == MEM;
            halted   <= nxt == HALT;
            illegal  <= st == DECODE && ill;
            if (i_ok) ir <= imem_data;
            if (st == DECODE) begin
                a <= regs[rd];
                b <= (op == 4'h3 || op == 4'h8) ? DATA_W'(ir[15:0]) : regs[rs];
            end
            if (st == EXEC) begin
                res <= alu_op ? alu : b;
                if (alu_op) z <= alu == '0;
                if (op == 4'hC || op == 4'hD) pc <= (op == 4'hC || z) ? PC_W'(ir[15:0]) : pc + PC_W'(1);
            end
            if (st == EXEC && nxt == MEM) begin
                dmem_we    <= op == 4'h4;
                dmem_addr  <= DADDR_W'(ir[15:0]);
                dmem_wdata <= a;
            end else if (nxt != MEM) begin
                dmem_we <= 1'b0;
            end
            if (d_ok) res <= dmem_rdata;
            if (st == WB) begin
                if (wr) regs[rd] <= res;
                if (wr) dbg_out <= res;
                pc <= pc + PC_W'(1);
            end
        end
    end

`ifdef MCYCLE_CORE_TIMEOUT_EN
    logic [7:0] cnt;
    logic waiting;
    assign waiting = (imem_req || dmem_req) && !(i_ok || d_ok);
    // cnt holds the number of completed wait cycles, so 254 here is the 255th unacked cycle
    assign tout = waiting && cnt == 8'd254;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            cnt <= (waiting && !tout) ? cnt + 8'd1 : 8'd0;
            if (tout) bus_err <= 1'b1;
        end
    end
`else
    assign tout    = 1'b0;
    assign bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_mcycle_core.sv
// tb_mcycle_core: directed scoreboard bench for mcycle_core with wait-state memory models
module tb_mcycle_core;
    localparam int DW = 16;
    localparam int PW = 10;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic imem_req, imem_ack = 1'b0;
    logic [PW-1:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata = '0;
    logic [PW-1:0] pc;
    logic [2:0] state;
    logic [DW-1:0] dbg_out;
    logic halted, illegal, bus_err;

    logic [31:0] rom [1024];
    logic [DW-1:0] ram [256];
    int i_wait = 0, d_wait = 0, i_cnt = 0, d_cyc = 0;
    bit i_hold = 1'b0, pend = 1'b0;
    logic [31:0] cur_ir = '0;
    logic [AW+DW:0] d_rec = '0;
    int ill_cyc = 0, ill_bad = 0, d_unstable = 0;
    logic [63:0] exp_wb[$], obs_wb[$], exp_f[$], obs_f[$], exp_st[$], obs_st[$];
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    mcycle_core dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc(pc), .state(state), .dbg_out(dbg_out), .halted(halted), .illegal(illegal), .bus_err(bus_err)
    );

    // memory responders and observers, all acting away from the rising edge
    always @(negedge clk) begin
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (rst) begin
            i_cnt = 0;
            d_cyc = 0;
            pend  = 1'b0;
        end else begin
            if (pend) obs_wb.push_back(64'(dbg_out));
            pend = state == 3'd4 && (cur_ir[31:28] inside {4'h1, 4'h2, 4'h3, 4'h8, 4'h9});
            if (illegal) begin
                ill_cyc++;
                if (state != 3'd2) ill_bad++;
            end
            if (imem_req && !i_hold) begin
                if (i_cnt >= i_wait) begin
                    imem_ack  = 1'b1;
                    imem_data = rom[imem_addr];
                    cur_ir    = rom[imem_addr];
                    obs_f.push_back(64'(imem_addr));
                    i_cnt = 0;
                end else i_cnt++;
            end else i_cnt = 0;
            if (dmem_req) begin
                d_cyc++;
                if (d_cyc == 1) d_rec = {dmem_we, dmem_addr, dmem_wdata};
                else if (d_rec != {dmem_we, dmem_addr, dmem_wdata}) d_unstable++;
                if (d_cyc > d_wait) begin
                    dmem_ack = 1'b1;
                    d_cyc = 0;
                    if (dmem_we) begin
                        ram[dmem_addr] = dmem_wdata;
                        obs_st.push_back(64'({dmem_addr, dmem_wdata}));
                    end else dmem_rdata = ram[dmem_addr];
                end
            end else d_cyc = 0;
        end
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        tick(2);
        obs_wb.delete(); obs_f.delete(); obs_st.delete();
        exp_wb.delete(); exp_f.delete(); exp_st.delete();
        ill_cyc = 0; ill_bad = 0; d_unstable = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 32'hE000_0000;
    endtask

    task automatic wait_halt(string tag, int budget);
        for (int i = 0; i < budget && !halted; i++) tick(1);
        check(tag, 64'(halted), 64'd1);
    endtask

    task automatic drain(string tag, input logic [63:0] e[$], input logic [63:0] o[$]);
        check({tag, "_count"}, 64'(o.size()), 64'(e.size()));
        foreach (e[i]) if (i < o.size()) check(tag, o[i], e[i]);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;

        // reset state, then MOVI/MOVI/SUB/HALT with zero-wait memories
        hold_reset();
        check("rst_state", 64'(state), 64'd0);
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_dmem_req", 64'(dmem_req), 64'd0);
        check("rst_dmem_we", 64'(dmem_we), 64'd0);
        check("rst_dbg_out", 64'(dbg_out), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_bus_err", 64'(bus_err), 64'd0);
        rom[0] = 32'h8010_0005;
        rom[1] = 32'h8020_0003;
        rom[2] = 32'h1112_0000;
        rom[3] = 32'hE000_0000;
        exp_wb.push_back(64'd5); exp_wb.push_back(64'd3); exp_wb.push_back(64'd2);
        i_wait = 0; d_wait = 0;
        rst = 1'b0;
        tick(1);
        check("t1_imem_req_rise", 64'(imem_req), 64'd1);
        tick(14);
        check("t1_not_halted_yet", 64'(halted), 64'd0);
        tick(1);
        check("t1_halted", 64'(halted), 64'd1);
        check("t1_state_halt", 64'(state), 64'd5);
        check("t1_dbg_out", 64'(dbg_out), 64'd2);
        check("t1_pc", 64'(pc), 64'd3);
        check("t1_imem_req_halt", 64'(imem_req), 64'd0);
        drain("t1_wb", exp_wb, obs_wb);

        // store then load through a data memory with two wait states
        hold_reset();
        rom[0] = 32'h8030_00FF;
        rom[1] = 32'h4030_0010;
        rom[2] = 32'h2040_0010;
        rom[3] = 32'h9054_0000;
        rom[4] = 32'hE000_0000;
        ram[8'h10] = 16'hAAAA;
        exp_wb.push_back(64'h00FF); exp_wb.push_back(64'h00FF); exp_wb.push_back(64'h00FF);
        exp_st.push_back({40'd0, 8'h10, 16'h00FF});
        i_wait = 0; d_wait = 2;
        rst = 1'b0;
        wait_halt("t2_halted", 200);
        check("t2_ram", 64'(ram[8'h10]), 64'h00FF);
        check("t2_dmem_stable", 64'(d_unstable), 64'd0);
        drain("t2_wb", exp_wb, obs_wb);
        drain("t2_store", exp_st, obs_st);

        // BZ taken and not taken, then an illegal opcode, with one instruction wait state
        hold_reset();
        rom[0]     = 32'h8010_0002;
        rom[1]     = 32'h3110_0002;
        rom[2]     = 32'hD000_0020;
        rom[10'h20] = 32'h3010_0001;
        rom[10'h21] = 32'hD000_0030;
        rom[10'h22] = 32'h6110_1234;
        rom[10'h23] = 32'h9021_0000;
        rom[10'h24] = 32'hE000_0000;
        exp_wb.push_back(64'd2); exp_wb.push_back(64'd0); exp_wb.push_back(64'd1); exp_wb.push_back(64'd1);
        exp_f.push_back(64'h0);  exp_f.push_back(64'h1);  exp_f.push_back(64'h2);  exp_f.push_back(64'h20);
        exp_f.push_back(64'h21); exp_f.push_back(64'h22); exp_f.push_back(64'h23); exp_f.push_back(64'h24);
        i_wait = 1; d_wait = 0;
        rst = 1'b0;
        wait_halt("t3_halted", 300);
        check("t3_pc", 64'(pc), 64'h24);
        check("t3_dbg_out", 64'(dbg_out), 64'd1);
        check("t3_illegal_cycles", 64'(ill_cyc), 64'd1);
        check("t3_illegal_in_exec", 64'(ill_bad), 64'd0);
        drain("t3_wb", exp_wb, obs_wb);
        drain("t3_fetch", exp_f, obs_f);

        // reset while a store waits in MEM
        hold_reset();
        rom[0] = 32'h8010_0007;
        rom[1] = 32'h4010_0005;
        rom[2] = 32'hE000_0000;
        ram[5] = 16'h1234;
        exp_wb.push_back(64'd7);
        i_wait = 0; d_wait = 20;
        rst = 1'b0;
        for (int i = 0; i < 50 && !dmem_req; i++) tick(1);
        check("t4_dmem_req_seen", 64'(dmem_req), 64'd1);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("t4_dmem_req", 64'(dmem_req), 64'd0);
        check("t4_imem_req", 64'(imem_req), 64'd0);
        check("t4_state", 64'(state), 64'd0);
        check("t4_pc", 64'(pc), 64'd0);
        check("t4_dbg_out", 64'(dbg_out), 64'd0);
        check("t4_ram_untouched", 64'(ram[5]), 64'h1234);
        drain("t4_wb", exp_wb, obs_wb);
        drain("t4_store", exp_st, obs_st);

        // instruction bus that never acks
        hold_reset();
        i_hold = 1'b1;
        rst = 1'b0;
        tick(1);
        check("t5_imem_req_rise", 64'(imem_req), 64'd1);
`ifdef MCYCLE_CORE_TIMEOUT_EN
        tick(254);
        check("t5_bus_err_early", 64'(bus_err), 64'd0);
        check("t5_halted_early", 64'(halted), 64'd0);
        tick(1);
        check("t5_bus_err", 64'(bus_err), 64'd1);
        check("t5_halted", 64'(halted), 64'd1);
        check("t5_imem_req_drop", 64'(imem_req), 64'd0);
        check("t5_state", 64'(state), 64'd5);
`else
        tick(300);
        check("t5_bus_err", 64'(bus_err), 64'd0);
        check("t5_halted", 64'(halted), 64'd0);
        check("t5_imem_req_held", 64'(imem_req), 64'd1);
        check("t5_state", 64'(state), 64'd0);
`endif
        i_hold = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
